// File: rtl/ors_out_arbiter.sv
// ============================================================================
// Module   : ors_out_arbiter
// Purpose  : Round-robin, wormhole-locking, credit-gated output arbiter.
//            Optional stall watchdog enabled by ORS_ARB_WDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ors_out_arbiter #(
    parameter int CREDITS    = 4,
    parameter int CNT_W      = 3,
    parameter int WDOG_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req1,
    input  logic             req2,
    input  logic             req3,
    input  logic             req4,
    input  logic             tail1,
    input  logic             tail2,
    input  logic             tail3,
    input  logic             tail4,
    input  logic             credit_in,
    output logic             gnt1,
    output logic             gnt2,
    output logic             gnt3,
    output logic             gnt4,
    output logic             busy,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             cred_err,
    output logic             wdog_err
);

    if (CREDITS < 1 || CREDITS >= (1 << CNT_W) || WDOG_LIMIT < 1) begin : g_param_check
        $error("ors_out_arbiter: illegal CREDITS/CNT_W/WDOG_LIMIT combination");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_credits = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_nxt;
    logic [1:0]       r_rr_ptr;
    logic [1:0]       w_rr_nxt;
    logic [CNT_W-1:0] r_credit_cnt;
    logic [CNT_W-1:0] w_credit_nxt;
    logic             r_cred_err;
    logic             w_cred_ovf;

    logic [3:0]       w_req;
    logic [3:0]       w_tail;
    logic [7:0]       w_req_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_pick;
    logic             w_has_credit;
    logic [3:0]       w_gnt;
    logic             w_xfer;
    logic             w_tail_xfer;
    logic             w_wdog_fire;

    assign w_req  = {req4, req3, req2, req1};
    assign w_tail = {tail4, tail3, tail2, tail1};

    assign w_has_credit = (r_credit_cnt != '0);

    // Grant depends only on registered state and the owner's request.
    assign w_gnt = {4{(r_state == ST_LOCKED) & w_has_credit}} & w_req & (4'b0001 << r_owner);
    assign w_xfer      = |w_gnt;
    assign w_tail_xfer = w_xfer & w_tail[r_owner];

    assign gnt1 = w_gnt[0];
    assign gnt2 = w_gnt[1];
    assign gnt3 = w_gnt[2];
    assign gnt4 = w_gnt[3];

    // Rotate requests so bit 0 is the requester rr_ptr points at.
    assign w_req_dbl = {w_req, w_req};
    assign w_rot     = w_req_dbl[r_rr_ptr +: 4];

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign w_pick = r_rr_ptr + w_off;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if ((|w_req) && w_has_credit) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_pick;
                end
            end
            ST_LOCKED: begin
                if (w_tail_xfer || w_wdog_fire) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = r_owner + 2'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_credit_nxt = r_credit_cnt;
        w_cred_ovf   = 1'b0;
        case ({w_xfer, credit_in})
            2'b10: w_credit_nxt = r_credit_cnt - c_one;
            2'b01: begin
                if (r_credit_cnt == c_credits) w_cred_ovf   = 1'b1;
                else                           w_credit_nxt = r_credit_cnt + c_one;
            end
            default: w_credit_nxt = r_credit_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= 2'd0;
            r_rr_ptr     <= 2'd0;
            r_credit_cnt <= c_credits;
            r_cred_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_credit_cnt <= w_credit_nxt;
            if (w_cred_ovf) r_cred_err <= 1'b1;
        end
    end

`ifdef ORS_ARB_WDOG_EN
    localparam int c_wd_w = $clog2(WDOG_LIMIT + 1);

    logic [c_wd_w-1:0] r_wdog_cnt;
    logic              r_wdog_err;

    // Fires on the WDOG_LIMIT-th consecutive stalled cycle of a lock.
    assign w_wdog_fire = (r_state == ST_LOCKED) && !w_xfer &&
                         (r_wdog_cnt == c_wd_w'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state != ST_LOCKED || w_xfer || w_wdog_fire) r_wdog_cnt <= '0;
            else                                               r_wdog_cnt <= r_wdog_cnt + c_wd_w'(1);
            if (w_wdog_fire) r_wdog_err <= 1'b1;
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign w_wdog_fire = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    assign busy       = (r_state == ST_LOCKED);
    assign credit_cnt = r_credit_cnt;
    assign cred_err   = r_cred_err;

endmodule

`default_nettype wire

// File: tb/tb_ors_out_arbiter.sv
// ============================================================================
// Module   : tb_ors_out_arbiter
// Purpose  : Directed, self-checking bench for ors_out_arbiter with a
//            behavioural model compared every cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ors_out_arbiter;

    localparam int CREDITS    = 4;
    localparam int CNT_W      = 3;
    localparam int WDOG_LIMIT = 8;
`ifdef ORS_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [3:0]       req;
    logic [3:0]       tail;
    logic             credit_in;
    logic             gnt1, gnt2, gnt3, gnt4;
    logic             busy;
    logic [CNT_W-1:0] credit_cnt;
    logic             cred_err;
    logic             wdog_err;

    int n_cmp = 0;
    int n_err = 0;
    int log_q[$];

    // Behavioural model state
    bit m_locked;
    int m_owner, m_rr, m_cred, m_stall;
    bit m_cerr, m_werr;
    int e_gnt, nc;
    bit xfer, found;

    ors_out_arbiter #(
        .CREDITS   (CREDITS),
        .CNT_W     (CNT_W),
        .WDOG_LIMIT(WDOG_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset_n),
        .req1      (req[0]),
        .req2      (req[1]),
        .req3      (req[2]),
        .req4      (req[3]),
        .tail1     (tail[0]),
        .tail2     (tail[1]),
        .tail3     (tail[2]),
        .tail4     (tail[3]),
        .credit_in (credit_in),
        .gnt1      (gnt1),
        .gnt2      (gnt2),
        .gnt3      (gnt3),
        .gnt4      (gnt4),
        .busy      (busy),
        .credit_cnt(credit_cnt),
        .cred_err  (cred_err),
        .wdog_err  (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    // Model and per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_locked = 1'b0; m_owner = 0; m_rr = 0; m_cred = CREDITS;
            m_cerr = 1'b0; m_werr = 1'b0; m_stall = 0;
        end
        e_gnt = 0;
        if (m_locked && req[m_owner] && m_cred > 0) e_gnt = 1 << m_owner;
        check("gnt", int'({gnt4, gnt3, gnt2, gnt1}), e_gnt);
        check("busy", int'(busy), int'(m_locked));
        check("credit_cnt", int'(credit_cnt), m_cred);
        check("cred_err", int'(cred_err), int'(m_cerr));
        check("wdog_err", int'(wdog_err), int'(m_werr));
        if (reset_n) begin
            xfer = (e_gnt != 0);
            if (xfer) log_q.push_back(m_owner + 1);
            if (!m_locked) begin
                if (req != 4'b0 && m_cred > 0) begin
                    found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        if (!found && req[(m_rr + k) % 4]) begin
                            m_owner = (m_rr + k) % 4;
                            found = 1'b1;
                        end
                    end
                    m_locked = 1'b1;
                    m_stall  = 0;
                end
            end else if (xfer) begin
                m_stall = 0;
                if (tail[m_owner]) begin
                    m_locked = 1'b0;
                    m_rr     = (m_owner + 1) % 4;
                end
            end else begin
                m_stall++;
                if (WDOG_ON && m_stall == WDOG_LIMIT) begin
                    m_locked = 1'b0;
                    m_rr     = (m_owner + 1) % 4;
                    m_werr   = 1'b1;
                    m_stall  = 0;
                end
            end
            nc = m_cred - int'(xfer) + int'(credit_in);
            if (nc > CREDITS) begin
                nc     = CREDITS;
                m_cerr = 1'b1;
            end
            m_cred = nc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_order[5];
        exp_order = '{1, 2, 3, 4, 1};

        // Reset with requests active
        reset_n = 1'b0; req = 4'hF; tail = 4'h0; credit_in = 1'b0;
        cyc(); cyc();
        #3;
        check("rst_gnt", int'({gnt4, gnt3, gnt2, gnt1}), 0);
        check("rst_credits", int'(credit_cnt), 4);
        check("rst_busy", int'(busy), 0);
        cyc();
        reset_n = 1'b1; req = 4'h0;
        cyc();

        // Single 3-flit packet from DM1
        log_q.delete();
        req = 4'b0001; tail = 4'b0000;
        cyc();
        cyc();
        cyc(); tail = 4'b0001;
        cyc(); req = 4'b0000; tail = 4'b0000;
        #3;
        check("pkt_credits", int'(credit_cnt), 1);
        check("pkt_busy", int'(busy), 0);
        check("pkt_flits", log_q.size(), 3);
        // rr_ptr now at requester 2: DM2 wins over DM1
        cyc(); req = 4'b0011; tail = 4'b0011;
        cyc();
        #3;
        check("rr_after_pkt_gnt2", int'(gnt2), 1);
        check("rr_after_pkt_gnt1", int'(gnt1), 0);
        cyc(); req = 4'b0000; tail = 4'b0000; credit_in = 1'b1;
        repeat (3) cyc();
        cyc(); credit_in = 1'b0;
        cyc();
        #3;
        check("credits_restored", int'(credit_cnt), 4);

        // Reset mid-packet drops grants without a clock edge
        cyc(); req = 4'b0001; tail = 4'b0000;
        cyc();
        cyc();
        #1;
        check("midpkt_gnt_before", int'(gnt1), 1);
        reset_n = 1'b0;
        #1;
        check("midpkt_gnt_after", int'(gnt1), 0);
        check("midpkt_credits", int'(credit_cnt), 4);
        cyc(); cyc();
        reset_n = 1'b1; req = 4'b0000;
        cyc();

        // Fairness with single-flit packets
        log_q.delete();
        for (int i = 0; i < 11; i++) begin
            req = 4'hF; tail = 4'hF;
            credit_in = (i >= 2 && i % 2 == 0);
            cyc();
        end
        req = 4'h0; tail = 4'h0; credit_in = 1'b0;
        #3;
        check("fair_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < log_q.size()) check("fair_order", log_q[i], exp_order[i]);
        check("fair_credits", int'(credit_cnt), 4);
        do_reset();

        // Credit exhaustion: DM2 6-flit packet, DM3 waiting
        log_q.delete();
        for (int i = 0; i < 11; i++) begin
            req = 4'b0110;
            tail = (i == 10) ? 4'b0010 : 4'b0000;
            credit_in = (i == 7 || i == 9);
            #3;
            if (i == 5) check("exh_stall_gnt2", int'(gnt2), 0);
            if (i == 7) check("exh_pulse_gnt2", int'(gnt2), 0);
            if (i == 8) check("exh_after_gnt2", int'(gnt2), 1);
            if (i == 8) check("exh_gnt3", int'(gnt3), 0);
            cyc();
        end
        req = 4'h0; tail = 4'h0; credit_in = 1'b0;
        #3;
        check("exh_flits", log_q.size(), 6);
        foreach (log_q[i]) check("exh_owner", log_q[i], 2);
        check("exh_credits", int'(credit_cnt), 0);
        do_reset();

        // Credit edges: simultaneous transfer/return, overflow
        req = 4'b0001; tail = 4'b0001;
        cyc(); credit_in = 1'b1;
        cyc(); req = 4'b0000; tail = 4'b0000; credit_in = 1'b0;
        #3;
        check("edge_same_cycle", int'(credit_cnt), 4);
        check("edge_no_err", int'(cred_err), 0);
        cyc(); credit_in = 1'b1;
        cyc(); credit_in = 1'b0;
        #3;
        check("ovf_credits", int'(credit_cnt), 4);
        check("ovf_err", int'(cred_err), 1);
        repeat (3) cyc();
        check("ovf_sticky", int'(cred_err), 1);
        do_reset();
        #3;
        check("ovf_cleared", int'(cred_err), 0);

        // Watchdog: DM1 locks then stalls, DM2 pending
        cyc(); req = 4'b0001; tail = 4'b0000;
        cyc();
        cyc(); req = 4'b0010;
        repeat (7) cyc();
        cyc();
        #3;
`ifdef ORS_ARB_WDOG_EN
        check("wdog_busy", int'(busy), 0);
        check("wdog_err", int'(wdog_err), 1);
`else
        check("nowdog_busy", int'(busy), 1);
        check("nowdog_err", int'(wdog_err), 0);
`endif
        cyc();
        #3;
`ifdef ORS_ARB_WDOG_EN
        check("wdog_gnt2", int'(gnt2), 1);
`else
        check("nowdog_gnt2", int'(gnt2), 0);
        repeat (20) cyc();
        check("nowdog_held", int'(busy), 1);
`endif
        req = 4'h0;
        do_reset();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
